// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks IF-stage conditional-branch predictions in a small
// circular queue, checks them against the EX-stage outcome and issues a one-cycle
// redirect/flush pulse on mispredict.
// Optional feature macro: BR_PERF_CNT_EN enables the saturating branch and
// mispredict performance counters; when undefined both counter outputs are tied to 0.

package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;
endpackage

module branch_resolve_unit
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        IF_is_br,
    input  logic [31:0] IF_pc,
    input  logic        IF_br_taken,
    input  logic [31:0] IF_pred_target,
    input  rv32i_opcode EX_opcode,
    input  logic [31:0] EX_pc,
    input  logic        EX_br_en,
    input  logic [31:0] EX_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        queue_full,
    output logic        overflow_err,
    output logic [31:0] br_count,
    output logic [31:0] mispredict_count
);

    // Count needs one extra bit to represent the full state (0..DEPTH).
    localparam int unsigned CntWidth = PTR_WIDTH + 1;

    // Prediction queue storage
    logic [31:0] q_pc     [DEPTH];
    logic        q_taken  [DEPTH];
    logic [31:0] q_target [DEPTH];

    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [CntWidth-1:0]  count_q, count_d;

    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        overflow_q, overflow_d;

    logic        queue_empty;
    logic        push_req;
    logic        resolve;
    logic        do_push;
    logic        do_pop;
    logic        mispredict;
    logic        dir_miss;
    logic        tgt_miss;
    logic        pc_miss;
    logic [31:0] ex_pc_plus4;
    logic [31:0] correct_pc;

    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    // The flush cycle squashes both the IF and EX instructions.
    assign flush          = redirect_valid_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign overflow_err   = overflow_q;

    assign queue_full  = (count_q == CntWidth'(DEPTH));
    assign queue_empty = (count_q == '0);

    assign push_req = IF_is_br & ~stall & ~flush;
    assign resolve  = (EX_opcode == op_br) & ~stall & ~flush;

    assign ex_pc_plus4 = EX_pc + 32'd4;
    assign correct_pc  = EX_br_en ? EX_target : ex_pc_plus4;

    // Predicted record: queue head, or a not-taken fall-through guess when empty.
    always_comb begin
        if (queue_empty) begin
            pred_pc     = EX_pc;
            pred_taken  = 1'b0;
            pred_target = ex_pc_plus4;
        end else begin
            pred_pc     = q_pc[head_q];
            pred_taken  = q_taken[head_q];
            pred_target = q_target[head_q];
        end
    end

    // Compare prediction with the actual outcome; a pc mismatch means a lost entry.
    always_comb begin
        dir_miss   = pred_taken != EX_br_en;
        tgt_miss   = pred_taken & EX_br_en & (pred_target != EX_target);
        pc_miss    = pred_pc != EX_pc;
        mispredict = resolve & (dir_miss | tgt_miss | pc_miss);
    end

    // A pop frees a slot in the same edge, so push while full is legal alongside it.
    assign do_pop  = resolve & ~queue_empty & ~mispredict;
    assign do_push = push_req & ~mispredict & (~queue_full | do_pop);

    // Queue pointer/count next state; a mispredict discards every wrong-path entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                head_d = head_q + PTR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntWidth'(1);
                2'b01:   count_d = count_q - CntWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Redirect target and sticky overflow next state.
    always_comb begin
        redirect_pc_d = redirect_pc_q;
        overflow_d    = overflow_q;
        if (mispredict) begin
            redirect_pc_d = correct_pc;
        end
        if (push_req & ~mispredict & queue_full & ~do_pop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            overflow_q       <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            // Mispredict is gated by ~flush, so the pulse can never be two cycles long.
            redirect_valid_q <= mispredict;
            redirect_pc_q    <= redirect_pc_d;
            overflow_q       <= overflow_d;
        end
    end

    // Queue payload write; data needs no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pc[tail_q]     <= IF_pc;
            q_taken[tail_q]  <= IF_br_taken;
            q_target[tail_q] <= IF_pred_target;
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [31:0] br_count_q;
    logic [31:0] mispredict_count_q;

    // Saturating performance counters; untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q         <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (resolve && (br_count_q != 32'hFFFF_FFFF)) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign br_count         = br_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign br_count         = 32'd0;
    assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, with expected
// redirect targets queued by the stimulus and consumed by a redirect monitor.

module tb_branch_resolve_unit;
    import rv32i_types::*;

`ifdef BR_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        if_is_br;
    logic [31:0] if_pc;
    logic        if_br_taken;
    logic [31:0] if_pred_target;
    rv32i_opcode ex_opcode;
    logic [31:0] ex_pc;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        queue_full;
    logic        overflow_err;
    logic [31:0] br_count;
    logic [31:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];
    logic        prev_rv = 1'b0;

    branch_resolve_unit #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .IF_is_br         (if_is_br),
        .IF_pc            (if_pc),
        .IF_br_taken      (if_br_taken),
        .IF_pred_target   (if_pred_target),
        .EX_opcode        (ex_opcode),
        .EX_pc            (ex_pc),
        .EX_br_en         (ex_br_en),
        .EX_target        (ex_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .queue_full       (queue_full),
        .overflow_err     (overflow_err),
        .br_count         (br_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pc_exp(input logic [31:0] v);
        return PerfEn ? v : 32'd0;
    endfunction

    // Monitor: every redirect pulse must match the oldest expected target.
    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid) begin
                chk("single_cycle_pulse", {31'd0, prev_rv}, 32'd0);
                chk("flush_with_redirect", {31'd0, flush}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_redirect: got pc 0x%08h expected no redirect at %0t",
                             redirect_pc, $time);
                end else begin
                    chk("redirect_pc", redirect_pc, exp_q.pop_front());
                end
            end
            prev_rv = redirect_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        if_is_br       = 1'b1;
        if_pc          = pc;
        if_br_taken    = tk;
        if_pred_target = tgt;
        cyc();
        if_is_br = 1'b0;
    endtask

    // Resolve one branch; when mis is set the expected redirect target is queued.
    task automatic resolve(input logic [31:0] pc, input logic en, input logic [31:0] tgt,
                           input logic mis, input logic [31:0] rpc);
        ex_opcode = op_br;
        ex_pc     = pc;
        ex_br_en  = en;
        ex_target = tgt;
        if (mis) exp_q.push_back(rpc);
        cyc();
        ex_opcode = op_imm;
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        if_is_br       = 1'b0;
        if_pc          = '0;
        if_br_taken    = 1'b0;
        if_pred_target = '0;
        ex_opcode      = op_imm;
        ex_pc          = '0;
        ex_br_en       = 1'b0;
        ex_target      = '0;
        #1;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_queue_full", {31'd0, queue_full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow_err}, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_mis_count", mispredict_count, 32'd0);
        #21 rst_n = 1'b1;
        cyc();

        // Correct taken prediction
        push(32'h100, 1'b1, 32'h140);
        chk("t1_count_after_push", 32'(dut.count_q), 32'd1);
        resolve(32'h100, 1'b1, 32'h140, 1'b0, 32'h0);
        cyc();
        chk("t1_count", 32'(dut.count_q), 32'd0);
        chk("t1_br_count", br_count, pc_exp(32'd1));
        chk("t1_mis_count", mispredict_count, pc_exp(32'd0));

        // Direction mispredict with younger wrong-path entries
        push(32'h200, 1'b0, 32'h240);
        push(32'h204, 1'b1, 32'h280);
        push(32'h208, 1'b0, 32'h20C);
        chk("t2_count_before", 32'(dut.count_q), 32'd3);
        resolve(32'h200, 1'b1, 32'h180, 1'b1, 32'h180);
        chk("t2_redirect_next_cycle", {31'd0, redirect_valid}, 32'd1);
        push(32'h999, 1'b1, 32'h9A0);  // lands in the flush cycle, must be squashed
        chk("t2_pulse_ended", {31'd0, redirect_valid}, 32'd0);
        chk("t2_count", 32'(dut.count_q), 32'd0);
        chk("t2_mis_count", mispredict_count, pc_exp(32'd1));
        chk("t2_br_count", br_count, pc_exp(32'd2));

        // Not-taken recovery wrapping past 2^32
        push(32'hFFFF_FFFC, 1'b1, 32'h0000_0010);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0000);
        cyc();
        chk("t3_count", 32'(dut.count_q), 32'd0);

        // Fill, overflow, then simultaneous push and pop while full
        push(32'h400, 1'b0, 32'h408);
        push(32'h404, 1'b0, 32'h40C);
        push(32'h408, 1'b0, 32'h410);
        chk("t4_not_full_at_3", {31'd0, queue_full}, 32'd0);
        push(32'h40C, 1'b0, 32'h414);
        chk("t4_full_at_4", {31'd0, queue_full}, 32'd1);
        chk("t4_no_overflow_yet", {31'd0, overflow_err}, 32'd0);
        push(32'h410, 1'b0, 32'h418);
        chk("t4_overflow", {31'd0, overflow_err}, 32'd1);
        chk("t4_still_full", {31'd0, queue_full}, 32'd1);
        if_is_br       = 1'b1;
        if_pc          = 32'h414;
        if_br_taken    = 1'b0;
        if_pred_target = 32'h41C;
        resolve(32'h400, 1'b0, 32'h408, 1'b0, 32'h0);
        if_is_br = 1'b0;
        chk("t4_count_push_pop_full", 32'(dut.count_q), 32'd4);
        chk("t4_full_after_push_pop", {31'd0, queue_full}, 32'd1);
        // Head is now 0x404; an unrelated EX pc is a lost entry
        resolve(32'h500, 1'b0, 32'h540, 1'b1, 32'h504);
        cyc();
        chk("t4_count_cleared", 32'(dut.count_q), 32'd0);
        chk("t4_overflow_sticky", {31'd0, overflow_err}, 32'd1);
        chk("t4_br_count", br_count, pc_exp(32'd5));
        chk("t4_mis_count", mispredict_count, pc_exp(32'd3));

        // Resolve against an empty queue
        resolve(32'h300, 1'b1, 32'h340, 1'b1, 32'h340);
        cyc();
        chk("t5_count", 32'(dut.count_q), 32'd0);
        chk("t5_mis_count", mispredict_count, pc_exp(32'd4));

        // Stalled mispredicting resolve
        push(32'h600, 1'b1, 32'h640);
        stall     = 1'b1;
        ex_opcode = op_br;
        ex_pc     = 32'h600;
        ex_br_en  = 1'b0;
        ex_target = 32'h640;
        cyc();
        cyc();
        cyc();
        chk("t6_no_redirect_in_stall", {31'd0, redirect_valid}, 32'd0);
        chk("t6_br_count_frozen", br_count, pc_exp(32'd6));
        chk("t6_count_held", 32'(dut.count_q), 32'd1);
        stall = 1'b0;
        exp_q.push_back(32'h604);
        cyc();
        ex_opcode = op_imm;
        chk("t6_redirect_after_stall", {31'd0, redirect_valid}, 32'd1);
        stall = 1'b1;  // stall in the flush cycle must not stretch the pulse
        cyc();
        chk("t6_pulse_not_extended", {31'd0, redirect_valid}, 32'd0);
        stall = 1'b0;
        chk("t6_br_count", br_count, pc_exp(32'd7));
        chk("t6_mis_count", mispredict_count, pc_exp(32'd5));

        // Asynchronous reset in the middle of a redirect pulse
        resolve(32'h700, 1'b1, 32'h740, 1'b1, 32'h740);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("t7_rst_flush", {31'd0, flush}, 32'd0);
        chk("t7_rst_redirect_pc", redirect_pc, 32'd0);
        chk("t7_rst_overflow", {31'd0, overflow_err}, 32'd0);
        chk("t7_rst_br_count", br_count, 32'd0);
        chk("t7_rst_mis_count", mispredict_count, 32'd0);
        #3 rst_n = 1'b1;
        cyc();
        cyc();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
